// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard frame receiver: synchronizes and de-glitches ps2c, shifts in
// 11-bit frames on filtered falling edges, and reports good codes or frame errors.
module ps2_scan_receiver #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       err_tick,
  output logic [1:0] err_code
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_FRAMING = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, RECV, LOAD} state_t;

  state_t                state;
  logic                  ps2c_p0, ps2c_p1;
  logic                  ps2d_p0, ps2d_p1;
  logic [FILTER_LEN-1:0] filt_p2;
  logic                  fval_p3, fval_p4;
  logic                  fall_edge;
  logic [3:0]            n_reg;
  logic [10:0]           b_reg;
  logic [TW-1:0]         tcnt;

  // Frame layout in b_reg: [0] start, [8:1] data LSB first, [9] odd parity, [10] stop.
  function automatic logic [1:0] frame_check(input logic [10:0] f);
    logic [1:0] res;
    res = ERR_NONE;
    if (!f[10] || f[0])
      res = ERR_FRAMING;
    else if (^f[9:1] != 1'b1)
      res = ERR_PARITY;
    return res;
  endfunction

  // Stage p0/p1: two-flop synchronizers; p2: ps2c history; p3/p4: filtered level and its delay
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps2c_p0 <= 1'b1;
      ps2c_p1 <= 1'b1;
      ps2d_p0 <= 1'b1;
      ps2d_p1 <= 1'b1;
      filt_p2 <= '1;
      fval_p3 <= 1'b1;
      fval_p4 <= 1'b1;
    end else begin
      ps2c_p0 <= ps2c;
      ps2c_p1 <= ps2c_p0;
      ps2d_p0 <= ps2d;
      ps2d_p1 <= ps2d_p0;
      filt_p2 <= {ps2c_p1, filt_p2[FILTER_LEN-1:1]};
      if (&filt_p2)
        fval_p3 <= 1'b1;
      else if (~|filt_p2)
        fval_p3 <= 1'b0;
      fval_p4 <= fval_p3;
    end
  end

  assign fall_edge = fval_p4 & ~fval_p3;

  // Frame FSM; ticks are registered so they appear the cycle after LOAD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      n_reg        <= 4'd0;
      b_reg        <= 11'd0;
      tcnt         <= '0;
      dout         <= 8'h00;
      rx_done_tick <= 1'b0;
      err_tick     <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      rx_done_tick <= 1'b0;
      err_tick     <= 1'b0;
      case (state)
        IDLE: begin
          if (fall_edge && rx_en && !ps2d_p1) begin
            b_reg <= {ps2d_p1, b_reg[10:1]};
            n_reg <= 4'd9;
            tcnt  <= '0;
            state <= RECV;
          end
        end
        RECV: begin
          if (fall_edge) begin
            b_reg <= {ps2d_p1, b_reg[10:1]};
            tcnt  <= '0;
            if (n_reg == 4'd0)
              state <= LOAD;
            else
              n_reg <= n_reg - 4'd1;
          end else if (tcnt == T_LAST) begin
            state    <= IDLE;
            b_reg    <= 11'd0;
            tcnt     <= '0;
            err_tick <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        LOAD: begin
          state <= IDLE;
          if (frame_check(b_reg) == ERR_NONE) begin
            dout         <= b_reg[8:1];
            rx_done_tick <= 1'b1;
          end else begin
            err_tick <= 1'b1;
            err_code <= frame_check(b_reg);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: bit-banged PS/2 frames with glitches,
// errors, timeout and mid-frame reset, checked with immediate assertions.
module tb_ps2_scan_receiver;

  localparam int FLEN = 8;
  localparam int TOUT = 200;
  localparam int HALF = 24;

  logic       clk;
  logic       reset;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       err_tick;
  logic [1:0] err_code;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int d0, e0;

  ps2_scan_receiver #(.FILTER_LEN(FLEN), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .dout(dout), .rx_done_tick(rx_done_tick), .err_tick(err_tick), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tick monitor samples 2ns after each rising edge, clear of the stimulus on the falling edge
  always begin
    @(posedge clk);
    #2;
    if (!reset) begin
      if (rx_done_tick) done_cnt++;
      if (err_tick) err_cnt++;
      if (rx_done_tick && err_tick) both_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitn(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    d0 = done_cnt;
    e0 = err_cnt;
  endtask

  // Sends the first nbits bits of {stop, par, data, start=0}; lo_gl/hi_gl place a
  // 6-cycle glitch inside the high/low half of the selected bits.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int nbits, input logic [10:0] lo_gl, input logic [10:0] hi_gl,
                            input int rst_at, input int en_drop_at);
    logic [10:0] bits;
    bits = {stop, par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      if (i == en_drop_at) rx_en = 1'b0;
      if (i == rst_at) begin
        waitn(16);
        reset = 1'b1;
        waitn(3);
        reset = 1'b0;
        waitn(5);
        ps2d = 1'b1;
        return;
      end
      if (lo_gl[i]) begin
        waitn(14); ps2c = 1'b0; waitn(FLEN - 2); ps2c = 1'b1; waitn(4);
      end else begin
        waitn(HALF);
      end
      ps2c = 1'b0;
      if (hi_gl[i]) begin
        waitn(14); ps2c = 1'b1; waitn(FLEN - 2); ps2c = 1'b0; waitn(4);
      end else begin
        waitn(HALF);
      end
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    rx_en = 1'b1;
    waitn(4);
    chk("rst_dout", dout, 8'h00);
    chk("rst_done", rx_done_tick, 1'b0);
    chk("rst_err", err_tick, 1'b0);
    chk("rst_code", err_code, 2'b00);
    reset = 1'b0;
    waitn(20);
    chk("idle_dout", dout, 8'h00);
    chk("idle_ticks", done_cnt + err_cnt, 0);

    // 0xF0, odd parity 1
    snap();
    send_frame(8'hF0, 1'b1, 1'b1, 11, 11'h0, 11'h0, -1, -1);
    waitn(40);
    chk("f0_done", done_cnt - d0, 1);
    chk("f0_err", err_cnt - e0, 0);
    chk("f0_dout", dout, 8'hF0);

    // Back-to-back 0xF0 then 0x1C
    snap();
    send_frame(8'hF0, 1'b1, 1'b1, 11, 11'h0, 11'h0, -1, -1);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 11'h0, 11'h0, -1, -1);
    waitn(40);
    chk("b2b_done", done_cnt - d0, 2);
    chk("b2b_err", err_cnt - e0, 0);
    chk("b2b_dout", dout, 8'h1C);

    // Parity error: 0x1C with parity 1
    snap();
    send_frame(8'h1C, 1'b1, 1'b1, 11, 11'h0, 11'h0, -1, -1);
    waitn(40);
    chk("par_err", err_cnt - e0, 1);
    chk("par_code", err_code, 2'b01);
    chk("par_done", done_cnt - d0, 0);
    chk("par_dout", dout, 8'h1C);

    // Framing error beats parity: 0x29, stop 0, wrong parity
    snap();
    send_frame(8'h29, 1'b1, 1'b0, 11, 11'h0, 11'h0, -1, -1);
    waitn(40);
    chk("frm_err", err_cnt - e0, 1);
    chk("frm_code", err_code, 2'b10);
    chk("frm_done", done_cnt - d0, 0);
    chk("frm_dout", dout, 8'h1C);

    // Timeout: frame stops after 5 bits
    snap();
    send_frame(8'h29, 1'b0, 1'b1, 5, 11'h0, 11'h0, -1, -1);
    waitn(150);
    chk("to_early", err_cnt - e0, 0);
    waitn(90);
    chk("to_err", err_cnt - e0, 1);
    chk("to_code", err_code, 2'b11);
    chk("to_done", done_cnt - d0, 0);
    snap();
    send_frame(8'h29, 1'b0, 1'b1, 11, 11'h0, 11'h0, -1, -1);
    waitn(40);
    chk("after_to_done", done_cnt - d0, 1);
    chk("after_to_dout", dout, 8'h29);

    // rx_en low at frame start: frame ignored
    snap();
    rx_en = 1'b0;
    send_frame(8'h33, 1'b1, 1'b1, 11, 11'h0, 11'h0, -1, -1);
    waitn(40);
    chk("en_off_ticks", (done_cnt - d0) + (err_cnt - e0), 0);
    chk("en_off_dout", dout, 8'h29);

    // rx_en dropped mid-frame does not abort
    rx_en = 1'b1;
    snap();
    send_frame(8'h5A, 1'b1, 1'b1, 11, 11'h0, 11'h0, -1, 3);
    waitn(40);
    rx_en = 1'b1;
    chk("en_drop_done", done_cnt - d0, 1);
    chk("en_drop_dout", dout, 8'h5A);

    // Short glitches in both phases leave the frame intact
    snap();
    send_frame(8'h3C, 1'b1, 1'b1, 11, 11'b000_1001_0100, 11'b100_0000_1000, -1, -1);
    waitn(40);
    chk("gl_done", done_cnt - d0, 1);
    chk("gl_err", err_cnt - e0, 0);
    chk("gl_dout", dout, 8'h3C);

    // Glitches plus reset pulsed at bit 6: partial frame dropped silently
    snap();
    send_frame(8'h77, 1'b0, 1'b1, 11, 11'b000_0001_0100, 11'b000_0000_1000, 6, -1);
    waitn(300);
    chk("rst_mid_done", done_cnt - d0, 0);
    chk("rst_mid_err", err_cnt - e0, 0);
    chk("rst_mid_dout", dout, 8'h00);
    chk("rst_mid_code", err_code, 2'b00);
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 11, 11'h0, 11'h0, -1, -1);
    waitn(40);
    chk("post_rst_done", done_cnt - d0, 1);
    chk("post_rst_err", err_cnt - e0, 0);
    chk("post_rst_dout", dout, 8'h1C);

    chk("ticks_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
